// File: rtl/data_ram_arbiter_pkg.sv
// Shared types and helpers for the data RAM arbiter: default sizes, the
// arbiter FSM state type and the rotate-priority search function.
package data_ram_pkg;

    localparam int N_CORES_DEF = 4;
    localparam int ADDR_W_DEF  = 32;
    localparam int DATA_W_DEF  = 32;
    localparam int MAX_CORES   = 8;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        LOCKED
    } arb_state_t;

    // Walks from lowest to highest priority so the last hit wins; returns
    // 'last' unchanged when nothing is valid (callers qualify with |valid).
    function automatic int rr_next(input int last, input logic [MAX_CORES-1:0] valid, input int n);
        int pick;
        int idx;
        pick = last;
        for (int off = MAX_CORES; off >= 1; off--) begin
            if (off <= n) begin
                idx = last + off;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (valid[3'(idx)]) begin
                    pick = idx;
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/data_ram_arbiter_rr_pick.sv
// Combinational rotate-priority picker: the search starts one past i_last
// and wraps, producing a one-hot grant plus its binary index.
module rr_pick
    import data_ram_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int IDX_W   = $clog2(N_CORES)
) (
    input  logic [IDX_W-1:0]   i_last,
    input  logic [N_CORES-1:0] i_valid,
    output logic [N_CORES-1:0] o_grant,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    always_comb begin
        o_any   = |i_valid;
        o_idx   = IDX_W'(rr_next(int'(i_last), MAX_CORES'(i_valid), N_CORES));
        o_grant = '0;
        for (int i = 0; i < N_CORES; i++) begin
            o_grant[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Round-robin arbiter merging N_CORES load/store channels onto one RAM port
// with a registered one-cycle response. Define ARB_LOCK_EN for locked RMW.
module data_ram_arbiter
    import data_ram_pkg::*;
#(
    parameter int N_CORES = N_CORES_DEF,
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [N_CORES-1:0]    i_req_valid,
    input  logic [N_CORES-1:0]    i_req_we,
    input  logic [N_CORES*ADDR_W-1:0] i_req_addr,
    input  logic [N_CORES*DATA_W-1:0] i_req_wdata,
`ifdef ARB_LOCK_EN
    input  logic [N_CORES-1:0]    i_req_lock,
`endif
    output logic [N_CORES-1:0]    o_req_ready,
    output logic [N_CORES-1:0]    o_rsp_valid,
    output logic [DATA_W-1:0]     o_rsp_rdata,
    output logic                  o_ram_we,
    output logic [ADDR_W-1:0]     o_ram_addr,
    output logic [DATA_W-1:0]     o_ram_wdata,
    input  logic [DATA_W-1:0]     i_ram_rdata
);

    localparam int IDX_W = $clog2(N_CORES);

    arb_state_t         r_state;
    logic [IDX_W-1:0]   r_last_grant;
    logic [N_CORES-1:0] r_rsp_valid;
    logic [DATA_W-1:0]  r_rsp_rdata;
    logic [N_CORES-1:0] w_eligible;
    logic [N_CORES-1:0] w_grant;
    logic [IDX_W-1:0]   w_idx;
    logic               w_any;

`ifdef ARB_LOCK_EN
    logic [IDX_W-1:0]   r_owner;
    logic [N_CORES-1:0] w_owner_mask;
    logic               w_lock;

    // While locked, every core except the owner is invisible to the picker.
    assign w_owner_mask = {{(N_CORES-1){1'b0}}, 1'b1} << r_owner;
    assign w_eligible   = (r_state == LOCKED) ? (i_req_valid & w_owner_mask) : i_req_valid;
    assign w_lock       = |(w_grant & i_req_lock);
`else
    assign w_eligible   = i_req_valid;
`endif

    rr_pick #(
        .N_CORES (N_CORES),
        .IDX_W   (IDX_W)
    ) u_pick (
        .i_last  (r_last_grant),
        .i_valid (w_eligible),
        .o_grant (w_grant),
        .o_idx   (w_idx),
        .o_any   (w_any)
    );

    assign o_req_ready = w_grant;
    assign o_rsp_valid = r_rsp_valid;
    assign o_rsp_rdata = r_rsp_rdata;

    always_comb begin
        o_ram_we    = 1'b0;
        o_ram_addr  = '0;
        o_ram_wdata = '0;
        for (int i = 0; i < N_CORES; i++) begin
            if (w_grant[i]) begin
                o_ram_we    = i_req_we[i];
                o_ram_addr  = i_req_addr[i*ADDR_W +: ADDR_W];
                o_ram_wdata = i_req_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    // Response capture and FSM; for stores rdata is the pre-write word.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= IDLE;
            r_last_grant <= IDX_W'(N_CORES - 1);
            r_rsp_valid  <= '0;
            r_rsp_rdata  <= '0;
`ifdef ARB_LOCK_EN
            r_owner      <= '0;
`endif
        end else begin
            r_rsp_valid <= w_grant;
            if (w_any) begin
                r_rsp_rdata  <= i_ram_rdata;
                r_last_grant <= w_idx;
            end
            case (r_state)
                IDLE, RUN: begin
                    r_state <= w_any ? RUN : IDLE;
`ifdef ARB_LOCK_EN
                    if (w_any && w_lock) begin
                        r_state <= LOCKED;
                        r_owner <= w_idx;
                    end
`endif
                end
`ifdef ARB_LOCK_EN
                LOCKED: begin
                    if (w_any && !w_lock) begin
                        r_state <= RUN;
                    end
                end
`endif
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Directed self-checking bench for data_ram_arbiter with a behavioural RAM
// (async read, write on clock edge). Lock scenario runs when ARB_LOCK_EN is set.
module tb_data_ram_arbiter;

    logic         clk;
    logic         rstN;
    logic [3:0]   reqValid;
    logic [3:0]   reqWe;
    logic [127:0] reqAddr;
    logic [127:0] reqWdata;
    logic [3:0]   reqReady;
    logic [3:0]   rspValid;
    logic [31:0]  rspRdata;
    logic         ramWe;
    logic [31:0]  ramAddr;
    logic [31:0]  ramWdata;
    logic [31:0]  ramRdata;
`ifdef ARB_LOCK_EN
    logic [3:0]   reqLock;
`endif

    logic [31:0]  mem [0:255];
    logic         preloadEn;
    logic [7:0]   preloadIdx;
    logic [31:0]  preloadData;

    int total;
    int bad;

    data_ram_arbiter #(
        .N_CORES (4),
        .ADDR_W  (32),
        .DATA_W  (32)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rstN),
        .i_req_valid (reqValid),
        .i_req_we    (reqWe),
        .i_req_addr  (reqAddr),
        .i_req_wdata (reqWdata),
`ifdef ARB_LOCK_EN
        .i_req_lock  (reqLock),
`endif
        .o_req_ready (reqReady),
        .o_rsp_valid (rspValid),
        .o_rsp_rdata (rspRdata),
        .o_ram_we    (ramWe),
        .o_ram_addr  (ramAddr),
        .o_ram_wdata (ramWdata),
        .i_ram_rdata (ramRdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ramRdata = mem[ramAddr[9:2]];

    always @(posedge clk) begin
        if (ramWe) begin
            mem[ramAddr[9:2]] <= ramWdata;
        end
        if (preloadEn) begin
            mem[preloadIdx] <= preloadData;
        end
    end

    task automatic clearReqs();
        reqValid = '0;
        reqWe    = '0;
        reqAddr  = '0;
        reqWdata = '0;
`ifdef ARB_LOCK_EN
        reqLock  = '0;
`endif
    endtask

    task automatic setReq(input int core, input logic we, input logic [31:0] addr, input logic [31:0] data);
        reqValid[core]           = 1'b1;
        reqWe[core]              = we;
        reqAddr[core*32 +: 32]   = addr;
        reqWdata[core*32 +: 32]  = data;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [7:0] idx, input logic [31:0] data);
        preloadIdx  = idx;
        preloadData = data;
        preloadEn   = 1'b1;
        stepCycle();
        preloadEn   = 1'b0;
    endtask

    task automatic test_reset();
        rstN = 1'b0;
        clearReqs();
        #2;
        total++; if (rspValid !== 4'b0000) begin bad++; $display("FAIL reset_rsp_valid: got %b expected %b", rspValid, 4'b0000); end
        total++; if (rspRdata !== 32'h0) begin bad++; $display("FAIL reset_rsp_rdata: got %h expected %h", rspRdata, 32'h0); end
        total++; if (reqReady !== 4'b0000) begin bad++; $display("FAIL reset_ready: got %b expected %b", reqReady, 4'b0000); end
        total++; if (ramWe !== 1'b0 || ramAddr !== 32'h0) begin bad++; $display("FAIL reset_ram_idle: got we=%b addr=%h expected we=0 addr=0", ramWe, ramAddr); end
        stepCycle();
        @(negedge clk);
        rstN = 1'b1;
        stepCycle();
    endtask

    task automatic test_single_read();
        preload(8'h10, 32'hDEADBEEF);
        setReq(2, 1'b0, 32'h40, 32'h0);
        #1;
        total++; if (reqReady !== 4'b0100) begin bad++; $display("FAIL read_ready: got %b expected %b", reqReady, 4'b0100); end
        total++; if (ramAddr !== 32'h40 || ramWe !== 1'b0) begin bad++; $display("FAIL read_ram_drive: got we=%b addr=%h expected we=0 addr=00000040", ramWe, ramAddr); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0100) begin bad++; $display("FAIL read_rsp_valid: got %b expected %b", rspValid, 4'b0100); end
        total++; if (rspRdata !== 32'hDEADBEEF) begin bad++; $display("FAIL read_rsp_rdata: got %h expected %h", rspRdata, 32'hDEADBEEF); end
    endtask

    task automatic test_store_ack();
        preload(8'h20, 32'h11111111);
        setReq(1, 1'b1, 32'h80, 32'h12345678);
        #1;
        total++; if (reqReady !== 4'b0010) begin bad++; $display("FAIL store_ready: got %b expected %b", reqReady, 4'b0010); end
        total++; if (ramWe !== 1'b1 || ramAddr !== 32'h80 || ramWdata !== 32'h12345678) begin
            bad++; $display("FAIL store_ram_drive: got we=%b addr=%h wdata=%h expected we=1 addr=00000080 wdata=12345678", ramWe, ramAddr, ramWdata);
        end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0010) begin bad++; $display("FAIL store_ack_valid: got %b expected %b", rspValid, 4'b0010); end
        total++; if (rspRdata !== 32'h11111111) begin bad++; $display("FAIL store_prewrite_rdata: got %h expected %h", rspRdata, 32'h11111111); end
        #1;
        total++; if (ramWe !== 1'b0 || ramAddr !== 32'h0) begin bad++; $display("FAIL store_we_one_cycle: got we=%b addr=%h expected we=0 addr=0", ramWe, ramAddr); end
        setReq(3, 1'b0, 32'h80, 32'h0);
        #1;
        total++; if (reqReady !== 4'b1000) begin bad++; $display("FAIL readback_ready: got %b expected %b", reqReady, 4'b1000); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b1000) begin bad++; $display("FAIL readback_valid: got %b expected %b", rspValid, 4'b1000); end
        total++; if (rspRdata !== 32'h12345678) begin bad++; $display("FAIL readback_rdata: got %h expected %h", rspRdata, 32'h12345678); end
        stepCycle();
        total++; if (rspValid !== 4'b0000) begin bad++; $display("FAIL idle_rsp_valid: got %b expected %b", rspValid, 4'b0000); end
        total++; if (rspRdata !== 32'h12345678) begin bad++; $display("FAIL idle_rdata_hold: got %h expected %h", rspRdata, 32'h12345678); end
    endtask

    task automatic test_fairness();
        int pulses [4];
        logic [3:0] expGrant;
        for (int c = 0; c < 4; c++) begin
            pulses[c] = 0;
        end
        @(negedge clk);
        rstN = 1'b0;
        @(negedge clk);
        rstN = 1'b1;
        stepCycle();
        for (int c = 0; c < 4; c++) begin
            setReq(c, 1'b0, 32'h200 + 32'(c * 4), 32'h0);
        end
        for (int k = 0; k < 8; k++) begin
            expGrant = 4'b0001 << (k % 4);
            #1;
            total++; if (reqReady !== expGrant) begin bad++; $display("FAIL fair_grant_%0d: got %b expected %b", k, reqReady, expGrant); end
            stepCycle();
            total++; if (rspValid !== expGrant) begin bad++; $display("FAIL fair_rsp_%0d: got %b expected %b", k, rspValid, expGrant); end
            for (int c = 0; c < 4; c++) begin
                if (rspValid[c]) pulses[c]++;
            end
        end
        clearReqs();
        for (int c = 0; c < 4; c++) begin
            total++; if (pulses[c] != 2) begin bad++; $display("FAIL fair_count_core%0d: got %0d expected 2", c, pulses[c]); end
        end
    endtask

    task automatic test_ordering();
        setReq(0, 1'b1, 32'h100, 32'hA5A5A5A5);
        setReq(1, 1'b0, 32'h100, 32'h0);
        #1;
        total++; if (reqReady !== 4'b0001 || ramWe !== 1'b1) begin bad++; $display("FAIL order_first: got ready=%b we=%b expected ready=0001 we=1", reqReady, ramWe); end
        stepCycle();
        reqValid[0] = 1'b0;
        reqWe[0]    = 1'b0;
        total++; if (rspValid !== 4'b0001) begin bad++; $display("FAIL order_store_ack: got %b expected %b", rspValid, 4'b0001); end
        #1;
        total++; if (reqReady !== 4'b0010 || ramWe !== 1'b0) begin bad++; $display("FAIL order_second: got ready=%b we=%b expected ready=0010 we=0", reqReady, ramWe); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0010) begin bad++; $display("FAIL order_load_valid: got %b expected %b", rspValid, 4'b0010); end
        total++; if (rspRdata !== 32'hA5A5A5A5) begin bad++; $display("FAIL order_load_rdata: got %h expected %h", rspRdata, 32'hA5A5A5A5); end
    endtask

    task automatic test_reset_midflight();
        setReq(0, 1'b0, 32'h40, 32'h0);
        #1;
        total++; if (reqReady !== 4'b0001) begin bad++; $display("FAIL midrst_grant: got %b expected %b", reqReady, 4'b0001); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0001) begin bad++; $display("FAIL midrst_pre_valid: got %b expected %b", rspValid, 4'b0001); end
        rstN = 1'b0;
        #1;
        total++; if (rspValid !== 4'b0000) begin bad++; $display("FAIL midrst_async_drop: got %b expected %b", rspValid, 4'b0000); end
        total++; if (rspRdata !== 32'h0) begin bad++; $display("FAIL midrst_rdata_clear: got %h expected %h", rspRdata, 32'h0); end
        @(negedge clk);
        rstN = 1'b1;
        stepCycle();
        total++; if (rspValid !== 4'b0000) begin bad++; $display("FAIL midrst_no_stale: got %b expected %b", rspValid, 4'b0000); end
        for (int c = 0; c < 4; c++) begin
            setReq(c, 1'b0, 32'h40, 32'h0);
        end
        #1;
        total++; if (reqReady !== 4'b0001) begin bad++; $display("FAIL midrst_priority: got %b expected %b", reqReady, 4'b0001); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0001) begin bad++; $display("FAIL midrst_post_valid: got %b expected %b", rspValid, 4'b0001); end
    endtask

`ifdef ARB_LOCK_EN
    task automatic test_lock();
        setReq(0, 1'b0, 32'h300, 32'h0);
        setReq(1, 1'b0, 32'h80, 32'h0);
        setReq(2, 1'b0, 32'h304, 32'h0);
        setReq(3, 1'b0, 32'h308, 32'h0);
        reqLock[1] = 1'b1;
        #1;
        total++; if (reqReady !== 4'b0010) begin bad++; $display("FAIL lock_first_grant: got %b expected %b", reqReady, 4'b0010); end
        stepCycle();
        total++; if (rspRdata !== 32'h12345678) begin bad++; $display("FAIL lock_load_rdata: got %h expected %h", rspRdata, 32'h12345678); end
        setReq(1, 1'b1, 32'h80, 32'hCAFEF00D);
        reqLock[1] = 1'b0;
        #1;
        total++; if (reqReady !== 4'b0010) begin bad++; $display("FAIL lock_owner_only: got %b expected %b", reqReady, 4'b0010); end
        stepCycle();
        reqValid[1] = 1'b0;
        reqWe[1]    = 1'b0;
        total++; if (rspValid !== 4'b0010) begin bad++; $display("FAIL lock_store_ack: got %b expected %b", rspValid, 4'b0010); end
        #1;
        total++; if (reqReady !== 4'b0100) begin bad++; $display("FAIL lock_release_grant: got %b expected %b", reqReady, 4'b0100); end
        stepCycle();
        clearReqs();
        total++; if (rspValid !== 4'b0100) begin bad++; $display("FAIL lock_release_rsp: got %b expected %b", rspValid, 4'b0100); end
        total++; if (mem[8'h20] !== 32'hCAFEF00D) begin bad++; $display("FAIL lock_store_data: got %h expected %h", mem[8'h20], 32'hCAFEF00D); end
    endtask
`endif

    initial begin
        total       = 0;
        bad         = 0;
        preloadEn   = 1'b0;
        preloadIdx  = '0;
        preloadData = '0;
        test_reset();
        test_single_read();
        test_store_ack();
        test_fairness();
        test_ordering();
        test_reset_midflight();
`ifdef ARB_LOCK_EN
        test_lock();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_ram_arbiter.md
Name: data_ram_arbiter

Overview:
- Round-robin arbiter that sits directly upstream of the shared data RAM.
- Merges N_CORES core-side load/store request channels onto the RAM's single port: we/addr/wdata out, asynchronous rdata back.
- Returns a registered, per-core-qualified response one cycle after each granted access.
- Guarantees at most one RAM access per cycle and bounded wait for every core.

Parameters:
- N_CORES, 4, number of requesting cores (2..8).
- ADDR_W, 32, byte address width.
- DATA_W, 32, data word width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_CORES  per-core request valid.
- req_we  in  N_CORES  per-core write enable (1 = store, 0 = load).
- req_addr  in  N_CORES*ADDR_W  packed byte addresses, core i at [i*ADDR_W +: ADDR_W].
- req_wdata  in  N_CORES*DATA_W  packed store data, same packing.
- req_ready  out  N_CORES  one-hot grant; request accepted when valid & ready.
- rsp_valid  out  N_CORES  one-hot response strobe, one cycle after acceptance.
- rsp_rdata  out  DATA_W  shared response data, qualified by rsp_valid.
- ram_we  out  1  to RAM write enable.
- ram_addr  out  ADDR_W  to RAM address.
- ram_wdata  out  DATA_W  to RAM write data.
- ram_rdata  in  DATA_W  from RAM, combinational read of ram_addr.

Behaviour:
- Reset (async, rst_n=0):
  - rsp_valid=0, rsp_rdata=0.
  - Round-robin pointer last_grant = N_CORES-1, so core 0 has highest priority first.
  - FSM = IDLE.
- Grant (combinational):
  - Search order starts at last_grant+1 mod N_CORES and wraps.
  - The first core with req_valid=1 gets req_ready=1. Exactly zero or one bit of req_ready is set.
- RAM drive (combinational):
  - ram_addr = req_addr of the granted core; ram_wdata = its req_wdata; ram_we = granted & its req_we.
  - With no grant: ram_we=0, ram_addr=0, ram_wdata=0.
  - addr[1:0] is passed through untouched; the RAM ignores it.
- Acceptance at edge N:
  - last_grant <= granted index.
  - rsp_valid <= one-hot of the granted index, at edge N, visible cycle N+1.
  - rsp_rdata <= ram_rdata sampled at edge N.
  - Stores also get a rsp_valid ack. For a store, rsp_rdata holds the pre-write word (the async read of old contents).
  - With no grant: rsp_valid <= 0 and rsp_rdata holds its previous value.
- Latency and throughput:
  - Request to response is exactly 1 cycle.
  - Throughput is 1 access per cycle, back-to-back, no bubbles.
  - There is no response backpressure; cores must sink rsp in the cycle it is valid.
- Request rules:
  - A core holds req_valid/req_we/req_addr/req_wdata stable until it sees req_ready.
  - A core may drop req_valid only after acceptance.
  - A core may issue its next request in the same cycle it receives rsp_valid.
- Fairness: with all cores requesting continuously, grants rotate 0,1,2,3,0,... Worst-case wait is N_CORES-1 cycles.
- Simultaneous events:
  - A request from the core that was just granted gets lowest priority next cycle.
  - Same-address load and store from different cores serialize in grant order. A later load sees the earlier store.
- Reset mid-operation: any in-flight response is dropped. rsp_valid deasserts immediately (asynchronously) and no ack is produced after release.
- FSM states:
  - IDLE and RUN differ only for lock tracking. IDLE -> RUN on any grant; RUN -> IDLE on a cycle with no valid requests.
  - With ARB_LOCK_EN, state LOCKED is added (below).

Optional Feature:
- Macro ARB_LOCK_EN enables atomic read-modify-write support.
- Defined:
  - Adds port req_lock (in, N_CORES).
  - An accepted request with req_lock=1 moves the FSM to LOCKED with owner = that core.
  - In LOCKED, only the owner can be granted; all other req_ready=0 regardless of priority.
  - The owner's next accepted request with req_lock=0 is granted and returns the FSM to RUN/IDLE. last_grant = owner.
  - Reset clears the lock.
- Undefined: port absent, no LOCKED state, pure round-robin.

Decomposition:
- Package data_ram_pkg:
  - N_CORES_DEF, ADDR_W_DEF, DATA_W_DEF.
  - typedef arb_state_t {IDLE, RUN, LOCKED}.
  - Function rr_next(last, valid) returning the granted index.
- One sub-module, rr_pick: combinational rotate-priority one-hot picker, parameterized by N_CORES.

Test Plan:
- Single read: mem[0x10]=0xDEADBEEF preloaded; core2 reads addr 0x40 -> req_ready=0100 that cycle; next cycle rsp_valid=0100, rsp_rdata=0xDEADBEEF.
- Store ack: core1 writes 0x12345678 to 0x80 -> ram_we=1, ram_addr=0x80 for one cycle; rsp_valid=0010 next cycle; a later core3 read of 0x80 returns 0x12345678.
- Fairness: all 4 cores hold req_valid for 8 cycles after reset -> grant sequence 0,1,2,3,0,1,2,3; each core gets exactly 2 rsp_valid pulses.
- Ordering: core0 stores 0xA5A5A5A5 to 0x100 and core1 loads 0x100 in the same cycle -> core0 granted first; core1's rsp_rdata = 0xA5A5A5A5.
- Reset mid-flight: assert rst_n=0 in the cycle after core0's acceptance -> rsp_valid=0 immediately. After release, core0 is highest priority and no stale response appears.
- ARB_LOCK_EN: core1 locked load then unlocked store while cores 0, 2, 3 request -> only core1 granted for both accesses; core2 is granted on the following cycle.
